// File: rtl/jtpopeye_txt_dma.sv
// Text-layer DMA for the Popeye board: copies a tile-code string from the source
// ROM into the 32x32 text RAM and fills the matching colour cells over the CPU text bus.
module jtpopeye_txt_dma #(
  parameter int         SRC_AW = 11,
  parameter logic [7:0] TERM   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cen,
  input  logic              start,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [4:0]        dst_row,
  input  logic [4:0]        dst_col,
  input  logic [5:0]        len,
  input  logic [3:0]        colour,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic [12:0]       AD,
  output logic [7:0]        DD,
  output logic              CSV,
  output logic              MEMWRO,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WCHR,
    S_WCOL,
    S_REL
  } state_t;

  state_t            state;
  logic              hold;
  logic [SRC_AW-1:0] ptr;
  logic [SRC_AW-1:0] ptr_nxt;
  logic [4:0]        row;
  logic [4:0]        col;
  logic [5:0]        cnt;
  logic [3:0]        colr;
  logic [7:0]        chr;

  assign ptr_nxt = ptr + SRC_AW'(1);

  // Character plane lives at 0x000, colour plane at 0x400.
  function automatic logic [12:0] cell_addr(input logic colour_plane,
                                            input logic [4:0] r,
                                            input logic [4:0] c);
    return {2'b00, colour_plane, r, c};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hold     <= 1'b0;
      ptr      <= '0;
      row      <= '0;
      col      <= '0;
      cnt      <= '0;
      colr     <= '0;
      chr      <= '0;
      src_addr <= '0;
      bus_req  <= 1'b0;
      AD       <= '0;
      DD       <= '0;
      CSV      <= 1'b0;
      MEMWRO   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr  <= src_base;
            row  <= dst_row;
            col  <= dst_col;
            cnt  <= len;
            colr <= colour;
            hold <= 1'b0;
            if (len == 6'd0) begin
              done <= 1'b1;
            end else begin
              state   <= S_REQ;
              busy    <= 1'b1;
              bus_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (cpu_cen && bus_ack) begin
            state    <= S_READ;
            src_addr <= ptr;
          end
        end
        S_READ, S_WCHR, S_WCOL: begin
          if (!bus_ack) begin
            // Bus taken away: release the lines at once and replay this step later
            hold   <= 1'b1;
            AD     <= '0;
            DD     <= '0;
            CSV    <= 1'b0;
            MEMWRO <= 1'b0;
          end else if (cpu_cen && hold) begin
            hold <= 1'b0;
            case (state)
              S_WCHR: begin
                AD     <= cell_addr(1'b0, row, col);
                DD     <= chr;
                CSV    <= 1'b1;
                MEMWRO <= 1'b1;
              end
              S_WCOL: begin
                AD     <= cell_addr(1'b1, row, col);
                DD     <= {4'b0000, colr};
                CSV    <= 1'b1;
                MEMWRO <= 1'b1;
              end
              default: src_addr <= ptr;
            endcase
          end else if (cpu_cen) begin
            case (state)
              S_READ: begin
                if (src_data == TERM) begin
                  state   <= S_REL;
                  bus_req <= 1'b0;
                end else begin
                  chr    <= src_data;
                  state  <= S_WCHR;
                  AD     <= cell_addr(1'b0, row, col);
                  DD     <= src_data;
                  CSV    <= 1'b1;
                  MEMWRO <= 1'b1;
                end
              end
              S_WCHR: begin
                state <= S_WCOL;
                AD    <= cell_addr(1'b1, row, col);
                DD    <= {4'b0000, colr};
              end
              default: begin
                AD     <= '0;
                DD     <= '0;
                CSV    <= 1'b0;
                MEMWRO <= 1'b0;
                ptr    <= ptr_nxt;
                cnt    <= cnt - 6'd1;
                col    <= col + 5'd1;
                if (col == 5'd31) row <= row + 5'd1;
                if (cnt == 6'd1) begin
                  state   <= S_REL;
                  bus_req <= 1'b0;
                end else begin
                  state    <= S_READ;
                  src_addr <= ptr_nxt;
                end
              end
            endcase
          end
        end
        S_REL: begin
          if (cpu_cen) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_txt_dma.sv
// Bench for jtpopeye_txt_dma: ROM and text-RAM models, table vectors, bus-grant
// gaps, reset abort and randomized transfers checked against a cell-index model.
module tb_jtpopeye_txt_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_cen = 1'b0;
  logic        start = 1'b0;
  logic [10:0] src_base = '0;
  logic [4:0]  dst_row = '0;
  logic [4:0]  dst_col = '0;
  logic [5:0]  len = '0;
  logic [3:0]  colour = '0;
  logic [10:0] src_addr;
  logic [7:0]  src_data = '0;
  logic        bus_req;
  logic        bus_ack;
  logic [12:0] AD;
  logic [7:0]  DD;
  logic        CSV, MEMWRO, busy, done;

  jtpopeye_txt_dma #(.SRC_AW(11), .TERM(8'hFF)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .start(start),
    .src_base(src_base), .dst_row(dst_row), .dst_col(dst_col), .len(len),
    .colour(colour), .src_addr(src_addr), .src_data(src_data),
    .bus_req(bus_req), .bus_ack(bus_ack), .AD(AD), .DD(DD),
    .CSV(CSV), .MEMWRO(MEMWRO), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cen_div = 3;
  int cen_ph = 0;
  always @(posedge clk) begin
    if (cen_ph >= cen_div - 1) begin
      cen_ph  <= 0;
      cpu_cen <= 1'b1;
    end else begin
      cen_ph  <= cen_ph + 1;
      cpu_cen <= 1'b0;
    end
  end

  logic [7:0] rom [0:2047];
  always @(posedge clk) src_data <= rom[src_addr];

  // Bus arbiter: grants whenever requested unless forced off or randomly withheld
  logic ack_force_low = 1'b0;
  logic ack_rand = 1'b0;
  logic ack_bit = 1'b1;
  always @(negedge clk) ack_bit = ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  assign bus_ack = bus_req && !ack_force_low && ack_bit;

  // Text RAM: one input register sampled on cpu_cen
  logic [7:0]  ram     [0:8191];
  logic [7:0]  exp_ram [0:8191];
  logic [20:0] wlog[$];
  logic [20:0] exp_q[$];
  always @(posedge clk) begin
    if (cpu_cen && CSV && MEMWRO) begin
      ram[AD] <= DD;
      wlog.push_back({AD, DD});
    end
  end

  logic ack_d = 1'b0;
  logic mon_en = 1'b0;
  int   viol = 0;
  int   done_cnt = 0;
  always @(posedge clk) ack_d <= bus_ack;
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_cnt++;
      if ((!ack_d || !busy) && (CSV || MEMWRO || AD != 13'd0 || DD != 8'd0)) viol++;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected writes: each character lands at linear cell (row*32+col+i) mod 1024
  task automatic build_model(input logic [10:0] b, input logic [4:0] r, input logic [4:0] c,
                             input logic [5:0] l, input logic [3:0] co, output int cells);
    int idx;
    logic [7:0] ch;
    exp_q.delete();
    cells = 0;
    for (int i = 0; i < int'(l); i++) begin
      ch = rom[(int'(b) + i) % 2048];
      if (ch == 8'hFF) break;
      idx = (int'(r) * 32 + int'(c) + i) % 1024;
      exp_q.push_back({13'(idx), ch});
      exp_q.push_back({13'(idx + 1024), 4'b0000, co});
      cells++;
    end
  endtask

  int model_cells;

  task automatic start_xfer(input logic [10:0] b, input logic [4:0] r, input logic [4:0] c,
                            input logic [5:0] l, input logic [3:0] co);
    build_model(b, r, c, l, co, model_cells);
    for (int a = 0; a < 8192; a++) exp_ram[a] = ram[a];
    foreach (exp_q[k]) exp_ram[exp_q[k][20:8]] = exp_q[k][7:0];
    @(negedge clk);
    wlog.delete();
    src_base = b; dst_row = r; dst_col = c; len = l; colour = co; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_base = ~b; dst_row = ~r; dst_col = ~c; len = 6'd7; colour = ~co;
  endtask

  task automatic wait_check(input string nm, input int exp_cens, input int exp_cells,
                            input bit exact_log, input bit poke);
    int cens, k0, a0, expw;
    bit got;
    cens = 0;
    got = 1'b0;
    for (int t = 0; t < 20000 && !got; t++) begin
      start = (poke && t == 10);
      @(posedge clk);
      if (cpu_cen) cens++;
      #1;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({nm, " done seen"}, longint'(got), 1);
    if (exp_cens >= 0) chk({nm, " cen count"}, longint'(cens), longint'(exp_cens));
    chk({nm, " busy at done"}, longint'(busy), 0);
    @(posedge clk);
    #1;
    chk({nm, " done width"}, longint'(done), 0);
    chk({nm, " bus_req after"}, longint'(bus_req), 0);
    if (exact_log) begin
      expw = (exp_cells >= 0) ? 2 * exp_cells : 2 * model_cells;
      chk({nm, " write count"}, longint'(wlog.size()), longint'(expw));
      if (wlog.size() > 0 && exp_q.size() > 0) begin
        k0 = 0;
        for (int k = 0; k < wlog.size() && k < exp_q.size(); k++)
          if (wlog[k] !== exp_q[k]) begin k0 = k; break; end
        chk({nm, " write seq"}, longint'(wlog[k0]), longint'(exp_q[k0]));
      end
    end
    a0 = 0;
    for (int a = 0; a < 8192; a++)
      if (ram[a] !== exp_ram[a]) begin a0 = a; break; end
    chk({nm, " ram"}, longint'(ram[a0]), longint'(exp_ram[a0]));
  endtask

  typedef struct {
    logic [10:0] base;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [5:0]  len;
    logic [3:0]  colour;
    int          cells;
    int          cens;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit   found, prev, cur, gap_done;
    int   nchr, n, dc;
    logic [10:0] b;
    logic [5:0]  l;
    int   pos;

    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom_range(0, 254));
    rom[11'h100] = "P"; rom[11'h101] = "O"; rom[11'h102] = "P"; rom[11'h103] = "E";
    rom[11'h300] = 8'h41; rom[11'h301] = 8'h42; rom[11'h302] = 8'hFF;
    rom[11'h2F0] = 8'hFF;

    vt[0] = '{11'h100, 5'd2,  5'd3,  6'd4,  4'h5, 4,  14};
    vt[1] = '{11'h200, 5'd31, 5'd30, 6'd4,  4'hA, 4,  14};
    vt[2] = '{11'h300, 5'd7,  5'd1,  6'd10, 4'h6, 2,  9};
    vt[3] = '{11'h400, 5'd0,  5'd0,  6'd32, 4'h3, 32, 98};
    vt[4] = '{11'h500, 5'd5,  5'd31, 6'd1,  4'hF, 1,  5};
    vt[5] = '{11'h2F0, 5'd9,  5'd9,  6'd8,  4'h1, 0,  3};

    repeat (4) @(posedge clk);
    #1;
    chk("reset outputs", longint'({bus_req, busy, done, CSV, MEMWRO, AD, DD, src_addr}), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    foreach (vt[i]) begin
      start_xfer(vt[i].base, vt[i].row, vt[i].col, vt[i].len, vt[i].colour);
      wait_check($sformatf("vec%0d", i), vt[i].cens, vt[i].cells, 1'b1, 1'b0);
      if (i == 0 && wlog.size() == 8) begin
        chk("pope first AD", longint'(wlog[0][20:8]), 13'h043);
        chk("pope first DD", longint'(wlog[0][7:0]), 8'h50);
        chk("pope last AD", longint'(wlog[7][20:8]), 13'h446);
      end
      if (i == 1 && wlog.size() == 8) begin
        chk("wrap cell2 AD", longint'(wlog[4][20:8]), 13'h000);
        chk("wrap cell1 AD", longint'(wlog[2][20:8]), 13'h3FF);
      end
    end

    // len == 0 is an immediate no-op
    @(negedge clk);
    len = 6'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("len0 done", longint'(done), 1);
    chk("len0 busy", longint'(busy), 0);
    found = bus_req;
    @(posedge clk);
    #1;
    chk("len0 done width", longint'(done), 0);
    chk("len0 bus_req", longint'(found | bus_req), 0);

    // start pulse during a transfer must be ignored
    start_xfer(11'h100, 5'd2, 5'd3, 6'd4, 4'h5);
    wait_check("poke", 14, 4, 1'b1, 1'b1);

    // grant withdrawn for 5 cpu_cen during the second character write
    start_xfer(11'h100, 5'd2, 5'd3, 6'd4, 4'h9);
    nchr = 0; prev = 1'b0; found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      @(negedge clk);
      cur = CSV && MEMWRO && !AD[10];
      if (cur && !prev) nchr++;
      prev = cur;
      if (nchr == 2) found = 1'b1;
    end
    chk("gap reach wchr2", longint'(found), 1);
    ack_force_low = 1'b1;
    n = 0; gap_done = 1'b0;
    for (int t = 0; t < 200 && n < 5; t++) begin
      @(posedge clk);
      if (cpu_cen) n++;
      #1;
      if (n == 2 && !gap_done) begin
        chk("gap strobes", longint'({CSV, MEMWRO}), 0);
        gap_done = 1'b1;
      end
    end
    @(negedge clk);
    ack_force_low = 1'b0;
    wait_check("ackgap", -1, 4, 1'b1, 1'b0);

    // reset during a colour write aborts cleanly
    start_xfer(11'h100, 5'd2, 5'd3, 6'd4, 4'h5);
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      @(negedge clk);
      if (CSV && MEMWRO && AD[10]) found = 1'b1;
    end
    chk("rst reach wcol", longint'(found), 1);
    dc = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst outputs", longint'({bus_req, busy, done, CSV, MEMWRO, AD, DD, src_addr}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst no done", longint'(done_cnt), longint'(dc));
    start_xfer(vt[0].base, vt[0].row, vt[0].col, vt[0].len, vt[0].colour);
    wait_check("after rst", 14, 4, 1'b1, 1'b0);

    // randomized transfers with a flaky grant
    ack_rand = 1'b1;
    for (int it = 0; it < 10; it++) begin
      cen_div = $urandom_range(2, 4);
      b = 11'($urandom_range(0, 2047));
      l = 6'($urandom_range(1, 32));
      pos = -1;
      if ($urandom_range(0, 2) == 0) begin
        pos = $urandom_range(0, int'(l) - 1);
        rom[(int'(b) + pos) % 2048] = 8'hFF;
      end
      start_xfer(b, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), l,
                 4'($urandom_range(0, 15)));
      wait_check($sformatf("rand%0d", it), -1, -1, 1'b0, 1'b0);
      if (pos >= 0) rom[(int'(b) + pos) % 2048] = 8'h00;
    end
    ack_rand = 1'b0;

    chk("bus idle zero", longint'(viol), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
